lock_code_entry: RTL and testbench

- Button-driven 4-digit hex code-entry and lock controller. Sits directly upstream of the seven-segment display driver and feeds its state[1:0] and hex1..hex4 inputs.
- Debounces five raw push buttons and lets the user edit a 4-digit hex code.
- Stores a password and runs an IDLE / LOCKED / UNLOCKED state machine with failed-attempt lockout.

---
 rtl/lock_code_entry.sv | 125 ++++++++++++
 tb/tb_lock_code_entry.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_code_entry.sv
// lock_code_entry: debounced 5-button hex code editor with password lock, fail counting and timed lockout
module lock_code_entry #(
  parameter int DEB_CYCLES     = 1000000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 500000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [1:0] state,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] hex4,
  output logic [1:0] cursor,
  output logic       locked_out
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, LOCKED = 2'b01, UNLOCKED = 2'b10} state_t;
  logic [4:0] btn, pls;
  assign btn = {btn_down, btn_up, btn_next, btn_clear, btn_enter};
  // Synchronizer resets to "pressed" so a button held through reset must be seen released before it is armed.
  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic s1_q, s2_q, deb_q, arm_q, pls_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        s1_q  <= 1'b1;
        s2_q  <= 1'b1;
        deb_q <= 1'b0;
        arm_q <= 1'b0;
        pls_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= btn[i];
        s2_q  <= s1_q;
        arm_q <= arm_q | ~s2_q;
        pls_q <= 1'b0;
        if (s2_q == deb_q) cnt_q <= '0;
        else if (cnt_q == CW'(DEB_CYCLES)) begin
          cnt_q <= '0;
          deb_q <= s2_q;
          pls_q <= s2_q & arm_q;
        end else cnt_q <= cnt_q + CW'(1);
      end
    end
    assign pls[i] = pls_q;
  end
  state_t        state_q, state_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [1:0]    cur_q, cur_d;
  logic [15:0]   pwd_q, pwd_d, code;
  logic [2:0]    fail_q, fail_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          lo_q;
  assign code = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    cur_d   = cur_q;
    pwd_d   = pwd_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    if (tmr_q != '0) begin
      tmr_d = tmr_q - TW'(1);
      fail_d = (tmr_q == TW'(1)) ? 3'd0 : fail_q;
    end else if (pls[0]) begin
      dig_d = '0;
      cur_d = '0;
      if (state_q == IDLE) begin
        pwd_d   = code;
        state_d = LOCKED;
      end else if (state_q == UNLOCKED) state_d = LOCKED;
      else if (code == pwd_q) begin
        state_d = UNLOCKED;
        fail_d  = '0;
      end else begin
        fail_d = fail_q + 3'd1;
        tmr_d  = (fail_d == 3'(MAX_FAILS)) ? TW'(LOCKOUT_CYCLES) : tmr_q;
      end
    end else if (pls[1]) begin
      if (state_q == UNLOCKED) begin
        state_d = IDLE;
        pwd_d   = '0;
        dig_d   = '0;
        cur_d   = '0;
      end
    end else if (state_q != UNLOCKED) begin
      if (pls[2]) cur_d = cur_q + 2'd1;
      else if (pls[3]) dig_d[cur_q] = dig_q[cur_q] + 4'd1;
      else if (pls[4]) dig_d[cur_q] = dig_q[cur_q] - 4'd1;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      cur_q   <= '0;
      pwd_q   <= '0;
      fail_q  <= '0;
      tmr_q   <= '0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cur_q   <= cur_d;
      pwd_q   <= pwd_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      lo_q    <= tmr_d != '0;
    end
  end
  assign state      = state_q;
  assign hex1       = dig_q[0];
  assign hex2       = dig_q[1];
  assign hex3       = dig_q[2];
  assign hex4       = dig_q[3];
  assign cursor     = cur_q;
  assign locked_out = lo_q;
endmodule

// File: tb/tb_lock_code_entry.sv
// tb_lock_code_entry: table vectors, timing sequences and random buttons checked against a window-based reference model
module tb_lock_code_entry;
  localparam int DEB = 4, MAXF = 3, LOCK = 20;
  logic clock = 1'b0, reset = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_next = 1'b0, btn_enter = 1'b0, btn_clear = 1'b0;
  logic [1:0] state, cursor;
  logic [3:0] hex1, hex2, hex3, hex4;
  logic locked_out;
  int tests = 0, fails = 0;

  lock_code_entry #(.DEB_CYCLES(DEB), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)) dut (
    .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .state(state), .hex1(hex1), .hex2(hex2),
    .hex3(hex3), .hex4(hex4), .cursor(cursor), .locked_out(locked_out));

  always #5 clock = ~clock;

  // Reference model: a button is accepted once its synchronized level (raw delayed two samples)
  // has held one value for DEB+1 consecutive samples; the action lands one clock later.
  int m_state, m_cur, m_pwd, m_fails, m_tmr, nvalid;
  int m_dig[4];
  logic [15:0] hist[5];
  bit m_deb[5], m_arm[5], m_pend[5];

  task automatic m_reset();
    m_state = 0; m_cur = 0; m_pwd = 0; m_fails = 0; m_tmr = 0; nvalid = 2;
    for (int d = 0; d < 4; d++) m_dig[d] = 0;
    for (int b = 0; b < 5; b++) begin
      hist[b] = '1; m_deb[b] = 0; m_arm[b] = 0; m_pend[b] = 0;
    end
  endtask

  task automatic m_edge(input logic [4:0] r);
    int sel, code;
    logic [DEB:0] win;
    sel = -1;
    for (int b = 4; b >= 0; b--) if (m_pend[b]) sel = b;
    code = m_dig[0] * 4096 + m_dig[1] * 256 + m_dig[2] * 16 + m_dig[3];
    if (m_tmr > 0) begin
      m_tmr--;
      if (m_tmr == 0) m_fails = 0;
    end else if (sel == 0) begin
      if (m_state == 0) begin m_pwd = code; m_state = 1; end
      else if (m_state == 2) m_state = 1;
      else if (code == m_pwd) begin m_state = 2; m_fails = 0; end
      else begin
        m_fails++;
        if (m_fails == MAXF) m_tmr = LOCK;
      end
      for (int d = 0; d < 4; d++) m_dig[d] = 0;
      m_cur = 0;
    end else if (sel == 1) begin
      if (m_state == 2) begin
        m_state = 0; m_pwd = 0; m_cur = 0;
        for (int d = 0; d < 4; d++) m_dig[d] = 0;
      end
    end else if (sel >= 2 && m_state != 2) begin
      if (sel == 2) m_cur = (m_cur + 1) % 4;
      else if (sel == 3) m_dig[m_cur] = (m_dig[m_cur] + 1) % 16;
      else m_dig[m_cur] = (m_dig[m_cur] + 15) % 16;
    end
    nvalid++;
    for (int b = 0; b < 5; b++) begin
      hist[b] = {hist[b][14:0], r[b]};
      m_pend[b] = 0;
      win = hist[b][DEB+2:2];
      if (nvalid >= DEB + 3) begin
        if (&win && !m_deb[b]) begin m_deb[b] = 1; m_pend[b] = m_arm[b]; end
        else if (!(|win) && m_deb[b]) m_deb[b] = 0;
      end
      if (!hist[b][2]) m_arm[b] = 1;
    end
  endtask

  function automatic logic [20:0] dut_out();
    return {state, hex1, hex2, hex3, hex4, cursor, locked_out};
  endfunction

  function automatic logic [20:0] model_out();
    return {2'(m_state), 4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3]), 2'(m_cur), m_tmr > 0};
  endfunction

  task automatic chk(input string nm, input logic [20:0] act, input logic [20:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] cur_btn();
    return {btn_down, btn_up, btn_next, btn_clear, btn_enter};
  endfunction

  task automatic set_btn(input logic [4:0] m);
    {btn_down, btn_up, btn_next, btn_clear, btn_enter} = m;
  endtask

  task automatic step();
    logic [4:0] r;
    r = cur_btn();
    @(posedge clock);
    m_edge(r);
    @(negedge clock);
    chk("model", dut_out(), model_out());
  endtask

  task automatic press(input logic [4:0] m);
    set_btn(m);
    repeat (8) step();
    set_btn(5'b0);
    repeat (12) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset_async", dut_out(), 21'h0);
    m_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  btn;
    logic [1:0]  st;
    logic [15:0] code;
    logic [1:0]  cur;
    logic        lo;
  } vec_t;
  vec_t tv[35];

  task automatic run_rows(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      press(tv[i].btn);
      chk($sformatf("vec%0d", i), dut_out(), {tv[i].st, tv[i].code, tv[i].cur, tv[i].lo});
    end
  endtask

  localparam logic [4:0] E = 5'b00001, C = 5'b00010, N = 5'b00100, U = 5'b01000, D = 5'b10000;

  initial begin
    int k;
    logic [4:0] b;
    tv = '{
      '{U, 2'd0, 16'h1000, 2'd0, 1'b0}, '{U, 2'd0, 16'h2000, 2'd0, 1'b0},
      '{U, 2'd0, 16'h3000, 2'd0, 1'b0}, '{N, 2'd0, 16'h3000, 2'd1, 1'b0},
      '{D, 2'd0, 16'h3F00, 2'd1, 1'b0}, '{E, 2'd1, 16'h0000, 2'd0, 1'b0},
      '{U, 2'd1, 16'h2000, 2'd0, 1'b0}, '{U, 2'd1, 16'h3000, 2'd0, 1'b0},
      '{N, 2'd1, 16'h3000, 2'd1, 1'b0}, '{D, 2'd1, 16'h3F00, 2'd1, 1'b0},
      '{E, 2'd2, 16'h0000, 2'd0, 1'b0}, '{U, 2'd2, 16'h0000, 2'd0, 1'b0},
      '{E, 2'd1, 16'h0000, 2'd0, 1'b0}, '{C, 2'd1, 16'h0000, 2'd0, 1'b0},
      '{E, 2'd1, 16'h0000, 2'd0, 1'b0}, '{E, 2'd1, 16'h0000, 2'd0, 1'b0},
      '{U, 2'd1, 16'h1000, 2'd0, 1'b0}, '{U, 2'd1, 16'h2000, 2'd0, 1'b0},
      '{U, 2'd1, 16'h3000, 2'd0, 1'b0}, '{N, 2'd1, 16'h3000, 2'd1, 1'b0},
      '{D, 2'd1, 16'h3F00, 2'd1, 1'b0}, '{E, 2'd2, 16'h0000, 2'd0, 1'b0},
      '{E, 2'd1, 16'h0000, 2'd0, 1'b0}, '{U, 2'd1, 16'h1000, 2'd0, 1'b0},
      '{U, 2'd1, 16'h2000, 2'd0, 1'b0}, '{U, 2'd1, 16'h3000, 2'd0, 1'b0},
      '{N, 2'd1, 16'h3000, 2'd1, 1'b0}, '{D, 2'd1, 16'h3F00, 2'd1, 1'b0},
      '{E | U, 2'd2, 16'h0000, 2'd0, 1'b0}, '{C, 2'd0, 16'h0000, 2'd0, 1'b0},
      '{D, 2'd0, 16'hF000, 2'd0, 1'b0}, '{E, 2'd1, 16'h0000, 2'd0, 1'b0},
      '{E, 2'd1, 16'h0000, 2'd0, 1'b0}, '{D, 2'd1, 16'hF000, 2'd0, 1'b0},
      '{E, 2'd2, 16'h0000, 2'd0, 1'b0}};
    #2;
    do_reset();
    repeat (5) step();
    chk("idle_after_reset", dut_out(), 21'h0);
    btn_up = 1'b1;
    repeat (3) step();
    btn_up = 1'b0;
    repeat (12) step();
    chk("short_bounce", dut_out(), 21'h0);
    run_rows(0, 5);
    btn_up = 1'b1;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (k == 0 && hex1 == 4'd1) k = c;
    end
    chki("up_latency", k, DEB + 4);
    chk("held_once", dut_out(), {2'd1, 16'h1000, 2'd0, 1'b0});
    btn_up = 1'b0;
    repeat (12) step();
    run_rows(6, 15);
    btn_enter = 1'b1;
    k = 0;
    while (locked_out !== 1'b1 && k < 20) begin step(); k++; end
    chki("lockout_rise", k, DEB + 4);
    btn_enter = 1'b0;
    btn_up = 1'b1;
    k = 0;
    while (locked_out === 1'b1 && k < 40) begin
      step();
      k++;
      if (k == 8) btn_up = 1'b0;
    end
    chki("lockout_len", k, LOCK);
    chk("lockout_digits", dut_out(), {2'd1, 16'h0000, 2'd0, 1'b0});
    repeat (12) step();
    run_rows(16, 34);
    b = 5'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) b[0] = ~b[0];
      if ($urandom_range(0, 19) == 0) b[1] = ~b[1];
      for (int j = 2; j < 5; j++) if ($urandom_range(0, 4) == 0) b[j] = ~b[j];
      set_btn(b);
      step();
    end
    set_btn(5'b0);
    repeat (12) step();
    btn_up = 1'b1;
    repeat (3) step();
    do_reset();
    repeat (30) step();
    chk("held_no_pulse", dut_out(), 21'h0);
    btn_up = 1'b0;
    repeat (12) step();
    press(U);
    chk("repress", dut_out(), {2'd0, 16'h1000, 2'd0, 1'b0});
    press(E);
    repeat (3) press(E);
    chk("lockout_again", dut_out(), {2'd1, 16'h0000, 2'd0, 1'b1});
    do_reset();
    repeat (30) step();
    chk("post_lock_reset", dut_out(), 21'h0);
    press(E);
    press(E);
    chk("zero_pwd_unlock", dut_out(), {2'd2, 16'h0000, 2'd0, 1'b0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
